// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: enables, funct3 encodings,
// FSM states and per-width byte-count constants.
package mem_access_stage_pkg;

   localparam logic        Enable   = 1'b1;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Load/store width encodings carried in funct3.
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Index of the final byte of an access (byte count minus one).
   localparam logic [1:0] LAST_BYTE_B = 2'd0;
   localparam logic [1:0] LAST_BYTE_H = 2'd1;
   localparam logic [1:0] LAST_BYTE_W = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   function automatic logic f3_supported(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic [1:0] last_byte(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return LAST_BYTE_B;
         F3_H, F3_HU: return LAST_BYTE_H;
         default:     return LAST_BYTE_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Load extension: turns the little-endian byte buffer into the final
// register value, sign- or zero-extended according to funct3.
module load_ext
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] load_buf,
   input  logic [2:0]  funct3,
   output logic [31:0] word
);

   // Select width and extension from the load encoding.
   always_comb begin
      // NOTE: assign a default first so no path leaves the output unassigned (no latch).
      word = ZeroWord;
      case (funct3)
         F3_B:    word = {{24{load_buf[7]}},  load_buf[7:0]};
         F3_H:    word = {{16{load_buf[15]}}, load_buf[15:0]};
         F3_BU:   word = {24'h00_0000, load_buf[7:0]};
         F3_HU:   word = {16'h0000,    load_buf[15:0]};
         default: word = load_buf;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: byte-serial loads/stores over the memory-controller port,
// with direct register-file writeback and upstream stall generation.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              dclk,
   input  logic              rst_n,
   input  logic              valid_EX_i,
   input  logic              mem_re_EX_i,
   input  logic              mem_we_EX_i,
   input  logic [2:0]        funct3_EX_i,
   input  logic [ADDR_W-1:0] addr_EX_i,
   input  logic [31:0]       sdata_EX_i,
   input  logic              rd_we_EX_i,
   input  logic [4:0]        rd_EX_i,
   input  logic [31:0]       result_EX_i,
   output logic              stall_CTRL_o,
   output logic              mem_req_MC_o,
   output logic              mem_wr_MC_o,
   output logic [ADDR_W-1:0] mem_addr_MC_o,
   output logic [7:0]        mem_wdata_MC_o,
   input  logic              mem_ack_MC_i,
   input  logic [7:0]        mem_rdata_MC_i,
   output logic              we_REG_o,
   output logic [4:0]        waddr_REG_o,
   output logic [31:0]       wdata_REG_o
);

   state_t      state, state_next;
   logic [1:0]  cnt;
   logic [2:0]  funct3_q;
   logic        store_q;
   logic [4:0]  rd_q;
   logic        rd_we_q;
   logic [31:0] sdata_q;
   logic [31:0] load_buf, load_buf_next;
   logic [31:0] load_word;
   logic        memop_ex;
   logic        last;
   logic        done;

   // Unsupported widths fall through as plain (non-writing) instructions.
   assign memop_ex = (mem_re_EX_i || mem_we_EX_i) && f3_supported(funct3_EX_i);
   assign last     = (cnt == last_byte(funct3_q));
   assign done     = (state == ST_ACCESS) && mem_ack_MC_i && last;

   // Buffer view including the byte arriving this cycle, so the final
   // byte is part of the written-back word on the same edge.
   always_comb begin
      load_buf_next                    = load_buf;
      load_buf_next[{cnt, 3'b000} +: 8] = mem_rdata_MC_i;
   end

   load_ext u_load_ext (
      .load_buf (load_buf_next),
      .funct3   (funct3_q),
      .word     (load_word)
   );

   // FSM state register.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_next;
      end
   end

   // Next state and combinational stall; stall is forced low during reset.
   always_comb begin
      state_next   = state;
      stall_CTRL_o = 1'b0;
      case (state)
         ST_IDLE: begin
            if (valid_EX_i && memop_ex) begin
               state_next   = ST_ACCESS;
               stall_CTRL_o = Enable;
            end
         end
         ST_ACCESS: begin
            if (done) state_next   = ST_IDLE;
            else      stall_CTRL_o = Enable;
         end
         default: state_next = ST_IDLE;
      endcase
      if (!rst_n) stall_CTRL_o = 1'b0;
   end

   // Datapath: access latching, byte loop, registered MC port and writeback.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= 2'd0;
         funct3_q       <= 3'd0;
         store_q        <= 1'b0;
         rd_q           <= 5'd0;
         rd_we_q        <= 1'b0;
         sdata_q        <= ZeroWord;
         load_buf       <= ZeroWord;
         mem_req_MC_o   <= 1'b0;
         mem_wr_MC_o    <= 1'b0;
         mem_addr_MC_o  <= '0;
         mem_wdata_MC_o <= 8'h00;
         we_REG_o       <= 1'b0;
         waddr_REG_o    <= 5'd0;
         wdata_REG_o    <= ZeroWord;
      end else begin
         we_REG_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid_EX_i && memop_ex) begin
                  cnt            <= 2'd0;
                  funct3_q       <= funct3_EX_i;
                  store_q        <= mem_we_EX_i;
                  rd_q           <= rd_EX_i;
                  rd_we_q        <= rd_we_EX_i;
                  sdata_q        <= sdata_EX_i;
                  load_buf       <= ZeroWord;
                  mem_req_MC_o   <= Enable;
                  mem_wr_MC_o    <= mem_we_EX_i;
                  mem_addr_MC_o  <= addr_EX_i;
                  mem_wdata_MC_o <= sdata_EX_i[7:0];
               end else if (valid_EX_i && !mem_re_EX_i && !mem_we_EX_i &&
                            rd_we_EX_i && (rd_EX_i != 5'd0)) begin
                  we_REG_o    <= Enable;
                  waddr_REG_o <= rd_EX_i;
                  wdata_REG_o <= result_EX_i;
               end
            end
            ST_ACCESS: begin
               if (mem_ack_MC_i) begin
                  if (!store_q) load_buf <= load_buf_next;
                  if (last) begin
                     mem_req_MC_o <= 1'b0;
                     cnt          <= 2'd0;
                     if (!store_q && rd_we_q && (rd_q != 5'd0)) begin
                        we_REG_o    <= Enable;
                        waddr_REG_o <= rd_q;
                        wdata_REG_o <= load_word;
                     end
                  end else begin
                     cnt            <= cnt + 2'd1;
                     mem_addr_MC_o  <= mem_addr_MC_o + ADDR_W'(1);
                     mem_wdata_MC_o <= sdata_q[{cnt + 2'd1, 3'b000} +: 8];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// loads/stores/ALU ops against a byte-array memory model.
module tb_mem_access_stage;

   localparam int ADDR_W = 32;

   logic              dclk = 1'b0;
   logic              rst_n;
   logic              valid_EX_i;
   logic              mem_re_EX_i;
   logic              mem_we_EX_i;
   logic [2:0]        funct3_EX_i;
   logic [ADDR_W-1:0] addr_EX_i;
   logic [31:0]       sdata_EX_i;
   logic              rd_we_EX_i;
   logic [4:0]        rd_EX_i;
   logic [31:0]       result_EX_i;
   logic              stall_CTRL_o;
   logic              mem_req_MC_o;
   logic              mem_wr_MC_o;
   logic [ADDR_W-1:0] mem_addr_MC_o;
   logic [7:0]        mem_wdata_MC_o;
   logic              mem_ack_MC_i;
   logic [7:0]        mem_rdata_MC_i;
   logic              we_REG_o;
   logic [4:0]        waddr_REG_o;
   logic [31:0]       wdata_REG_o;

   int vectors = 0;
   int errors  = 0;

   // Byte-addressed memory model; unknown locations get random contents.
   logic [7:0] mem [logic [31:0]];

   mem_access_stage #(.ADDR_W(ADDR_W)) dut (
      .dclk           (dclk),
      .rst_n          (rst_n),
      .valid_EX_i     (valid_EX_i),
      .mem_re_EX_i    (mem_re_EX_i),
      .mem_we_EX_i    (mem_we_EX_i),
      .funct3_EX_i    (funct3_EX_i),
      .addr_EX_i      (addr_EX_i),
      .sdata_EX_i     (sdata_EX_i),
      .rd_we_EX_i     (rd_we_EX_i),
      .rd_EX_i        (rd_EX_i),
      .result_EX_i    (result_EX_i),
      .stall_CTRL_o   (stall_CTRL_o),
      .mem_req_MC_o   (mem_req_MC_o),
      .mem_wr_MC_o    (mem_wr_MC_o),
      .mem_addr_MC_o  (mem_addr_MC_o),
      .mem_wdata_MC_o (mem_wdata_MC_o),
      .mem_ack_MC_i   (mem_ack_MC_i),
      .mem_rdata_MC_i (mem_rdata_MC_i),
      .we_REG_o       (we_REG_o),
      .waddr_REG_o    (waddr_REG_o),
      .wdata_REG_o    (wdata_REG_o)
   );

   // Free-running clock.
   always #5 dclk = ~dclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   function automatic int num_bytes(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   // Expected load result: little-endian value, then two's-complement
   // reinterpretation for the signed narrow widths.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      longint val = 0;
      int     n   = num_bytes(f3);
      for (int i = 0; i < n; i++)
         val = val + (longint'(mem_byte(addr + 32'(i))) << (8 * i));
      if (!f3[2] && n < 4 && val >= (longint'(1) << (8 * n - 1)))
         val = val - (longint'(1) << (8 * n));
      return val[31:0];
   endfunction

   task automatic set_idle();
      valid_EX_i  = 1'b0;
      mem_re_EX_i = 1'b0;
      mem_we_EX_i = 1'b0;
   endtask

   // Non-memory instruction: present, then check the writeback after the edge.
   task automatic do_alu(input logic [4:0] rd, input bit rd_we, input logic [31:0] result);
      valid_EX_i  = 1'b1;
      mem_re_EX_i = 1'b0;
      mem_we_EX_i = 1'b0;
      funct3_EX_i = 3'($urandom);
      addr_EX_i   = $urandom;
      sdata_EX_i  = $urandom;
      rd_EX_i     = rd;
      rd_we_EX_i  = rd_we;
      result_EX_i = result;
      #1 check("alu_stall", stall_CTRL_o, 1'b0);
      @(posedge dclk); #1;
      if (rd_we && rd != 5'd0) begin
         check("alu_we", we_REG_o, 1'b1);
         check("alu_waddr", waddr_REG_o, rd);
         check("alu_wdata", wdata_REG_o, result);
      end else begin
         check("alu_we_off", we_REG_o, 1'b0);
      end
      check("alu_req", mem_req_MC_o, 1'b0);
   endtask

   // Memory instruction with a fixed number of wait cycles before every ack.
   // EX holds its outputs while stalled and drops them after the final edge.
   task automatic do_access(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] rd, input bit rd_we,
                            input int waits);
      int          n;
      logic [31:0] exp_word;
      logic [31:0] a;
      n        = num_bytes(f3);
      exp_word = is_store ? 32'h0 : model_load(f3, addr);
      valid_EX_i  = 1'b1;
      mem_re_EX_i = !is_store;
      mem_we_EX_i = is_store;
      funct3_EX_i = f3;
      addr_EX_i   = addr;
      sdata_EX_i  = sdata;
      rd_EX_i     = rd;
      rd_we_EX_i  = rd_we;
      result_EX_i = $urandom;
      #1 check("stall_accept", stall_CTRL_o, 1'b1);
      @(posedge dclk); #1;
      for (int b = 0; b < n; b++) begin
         a = addr + 32'(b);
         for (int w = 0; w <= waits; w++) begin
            check("mc_req", mem_req_MC_o, 1'b1);
            check("mc_wr", mem_wr_MC_o, is_store);
            check("mc_addr", mem_addr_MC_o, a);
            if (is_store) check("mc_wdata", mem_wdata_MC_o, sdata[8*b +: 8]);
            check("we_busy", we_REG_o, 1'b0);
            mem_ack_MC_i   = (w == waits);
            mem_rdata_MC_i = mem_ack_MC_i ? mem_byte(a) : 8'($urandom);
            if (mem_ack_MC_i && is_store) mem[a] = sdata[8*b +: 8];
            #1 check("stall_busy", stall_CTRL_o, !(mem_ack_MC_i && b == n - 1));
            @(posedge dclk); #1;
         end
      end
      mem_ack_MC_i = 1'b0;
      set_idle();
      check("req_done", mem_req_MC_o, 1'b0);
      if (!is_store && rd_we && rd != 5'd0) begin
         check("ld_we", we_REG_o, 1'b1);
         check("ld_waddr", waddr_REG_o, rd);
         check("ld_wdata", wdata_REG_o, exp_word);
      end else begin
         check("no_we", we_REG_o, 1'b0);
      end
      #1 check("stall_after", stall_CTRL_o, 1'b0);
      @(posedge dclk); #1;
      check("we_pulse_end", we_REG_o, 1'b0);
      check("req_idle", mem_req_MC_o, 1'b0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      int          kind;
      rst_n          = 1'b0;
      set_idle();
      funct3_EX_i    = 3'd0;
      addr_EX_i      = '0;
      sdata_EX_i     = 32'h0;
      rd_we_EX_i     = 1'b0;
      rd_EX_i        = 5'd0;
      result_EX_i    = 32'h0;
      mem_ack_MC_i   = 1'b0;
      mem_rdata_MC_i = 8'h00;
      repeat (2) @(posedge dclk);
      #1;
      check("rst_req", mem_req_MC_o, 1'b0);
      check("rst_we", we_REG_o, 1'b0);
      check("rst_stall", stall_CTRL_o, 1'b0);
      check("rst_wdata", wdata_REG_o, 32'h0);
      rst_n = 1'b1;
      @(posedge dclk); #1;
      check("idle_we", we_REG_o, 1'b0);

      // ALU writeback, rd=0 suppression, back-to-back issue.
      do_alu(5'd5, 1'b1, 32'hDEADBEEF);
      do_alu(5'd0, 1'b1, 32'h12345678);
      do_alu(5'd9, 1'b0, 32'hCAFEF00D);
      do_alu(5'd31, 1'b1, 32'h0000_0001);
      set_idle();
      @(posedge dclk); #1;
      check("idle_no_we", we_REG_o, 1'b0);

      // LW at 0x100, zero-wait.
      mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
      mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
      do_access(1'b0, 3'd2, 32'h100, 32'h0, 5'd7, 1'b1, 0);
      check("lw_value", wdata_REG_o, 32'h44332211);

      // Load extension cases.
      mem[32'h200] = 8'h80;
      do_access(1'b0, 3'd0, 32'h200, 32'h0, 5'd1, 1'b1, 0);
      check("lb_80", wdata_REG_o, 32'hFFFFFF80);
      do_access(1'b0, 3'd4, 32'h200, 32'h0, 5'd2, 1'b1, 0);
      check("lbu_80", wdata_REG_o, 32'h00000080);
      mem[32'h210] = 8'h01; mem[32'h211] = 8'h80;
      do_access(1'b0, 3'd1, 32'h210, 32'h0, 5'd3, 1'b1, 0);
      check("lh_8001", wdata_REG_o, 32'hFFFF8001);
      do_access(1'b0, 3'd5, 32'h210, 32'h0, 5'd4, 1'b1, 0);
      check("lhu_8001", wdata_REG_o, 32'h00008001);

      // SH at 0x300, then read back.
      do_access(1'b1, 3'd1, 32'h300, 32'h1234ABCD, 5'd6, 1'b1, 0);
      check("sh_byte0", mem[32'h300], 8'hCD);
      check("sh_byte1", mem[32'h301], 8'hAB);
      do_access(1'b0, 3'd5, 32'h300, 32'h0, 5'd6, 1'b1, 0);

      // LW with 3 wait cycles before every ack; address wraps past the top.
      do_access(1'b0, 3'd2, 32'h100, 32'h0, 5'd8, 1'b1, 3);
      do_access(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 5'd8, 1'b1, 1);

      // Unsupported funct3: no access, no stall, no write.
      valid_EX_i  = 1'b1;
      mem_re_EX_i = 1'b1;
      funct3_EX_i = 3'd3;
      rd_EX_i     = 5'd10;
      rd_we_EX_i  = 1'b1;
      #1 check("bad_f3_stall", stall_CTRL_o, 1'b0);
      @(posedge dclk); #1;
      check("bad_f3_req", mem_req_MC_o, 1'b0);
      check("bad_f3_we", we_REG_o, 1'b0);
      set_idle();

      // Reset after two bytes of an LW.
      valid_EX_i  = 1'b1;
      mem_re_EX_i = 1'b1;
      funct3_EX_i = 3'd2;
      addr_EX_i   = 32'h500;
      rd_EX_i     = 5'd12;
      rd_we_EX_i  = 1'b1;
      @(posedge dclk); #1;
      mem_ack_MC_i   = 1'b1;
      mem_rdata_MC_i = 8'h5A;
      @(posedge dclk); #1;
      @(posedge dclk); #1;
      mem_ack_MC_i = 1'b0;
      check("pre_rst_addr", mem_addr_MC_o, 32'h502);
      check("pre_rst_stall", stall_CTRL_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", mem_req_MC_o, 1'b0);
      check("mid_rst_stall", stall_CTRL_o, 1'b0);
      check("mid_rst_we", we_REG_o, 1'b0);
      set_idle();
      #2 rst_n = 1'b1;
      @(posedge dclk); #1;
      check("post_rst_req", mem_req_MC_o, 1'b0);
      mem[32'h600] = 8'h7F;
      do_access(1'b0, 3'd0, 32'h600, 32'h0, 5'd13, 1'b1, 0);
      check("post_rst_lb", wdata_REG_o, 32'h0000007F);

      // Randomized mix over a small overlapping region.
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2))
                                            : 32'h400 + 32'($urandom_range(0, 15));
         if (kind == 0) begin
            do_alu(5'($urandom), 1'($urandom), $urandom);
            set_idle();
         end else if (kind == 1) begin
            case ($urandom_range(0, 4))
               0:       f3 = 3'd0;
               1:       f3 = 3'd1;
               2:       f3 = 3'd2;
               3:       f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
            do_access(1'b0, f3, addr, 32'h0, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
         end else begin
            f3 = 3'($urandom_range(0, 2));
            do_access(1'b1, f3, addr, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the RISC-V core. It takes one instruction at a time from EX and performs loads and stores over the byte-wide memory-controller port, one byte per handshake. It then drives the register file's write port (`we`/`waddr`/`wdata`) directly, replacing a separate MEM/WB register. While a memory access is in flight it stalls the upstream pipeline.

## Interface
- `ADDR_W`, 32: memory address width.
- `dclk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_EX_i` in 1: EX presents an instruction.
- `mem_re_EX_i` in 1: load.
- `mem_we_EX_i` in 1: store; has priority if both `mem_re_EX_i` and `mem_we_EX_i` are high.
- `funct3_EX_i` in 3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `addr_EX_i` in ADDR_W: effective address.
- `sdata_EX_i` in 32: store data.
- `rd_we_EX_i` in 1: instruction writes rd.
- `rd_EX_i` in 5: destination register.
- `result_EX_i` in 32: ALU result for non-memory instructions.
- `stall_CTRL_o` out 1: upstream must hold its outputs while high.
- `mem_req_MC_o` out 1: byte request.
- `mem_wr_MC_o` out 1: 1 = write, 0 = read.
- `mem_addr_MC_o` out ADDR_W: byte address.
- `mem_wdata_MC_o` out 8: byte to write.
- `mem_ack_MC_i` in 1: byte transfer completes this cycle.
- `mem_rdata_MC_i` in 8: read byte, valid when ack is high.
- `we_REG_o` out 1: register-file write enable; one-cycle pulse.
- `waddr_REG_o` out 5: register-file write address.
- `wdata_REG_o` out 32: register-file write data.

## Operation
- FSM states:
  - IDLE: accepts instructions.
  - ACCESS: byte loop.
- Latched on entry to ACCESS: address, store data, `funct3`, direction, `rd`, `rd_we`; byte counter `cnt` (2 bits) cleared.
- Non-memory instruction (`valid_EX_i=1`, `mem_re_EX_i=0`, `mem_we_EX_i=0`) in IDLE:
  - On the next edge: `we_REG_o = rd_we_EX_i && rd_EX_i != 0`, `waddr_REG_o = rd_EX_i`, `wdata_REG_o = result_EX_i`.
  - No stall.
- Memory instruction in IDLE:
  - `stall_CTRL_o` high; go to ACCESS.
  - Byte count n = 1 (B/BU), 2 (H/HU), 4 (W).
  - Unsupported `funct3`: no memory access; behaves as a non-memory instruction with `we_REG_o = 0`.
- ACCESS:
  - Drives `mem_req_MC_o=1`, `mem_wr_MC_o` = direction, `mem_addr_MC_o` = latched address + `cnt` (wraps modulo 2^ADDR_W).
  - Store: `mem_wdata_MC_o = sdata[8*cnt +: 8]`.
  - On ack, load: captures `mem_rdata_MC_i` into buffer byte `cnt`.
  - On ack, not last byte: `cnt++`, request stays high, address advances the next cycle.
  - Without ack: all MC outputs held stable.
  - Ack on the last byte (`cnt == n-1`): return to IDLE.
- Load writeback on the last-ack edge:
  - `we_REG_o = rd_we && rd != 0`; `waddr_REG_o = rd`.
  - `wdata_REG_o`: little-endian assembly; B/H sign-extended, BU/HU zero-extended.
- Store writeback: `we_REG_o = 0`.
- `stall_CTRL_o = (IDLE && valid_EX_i && memop) || (ACCESS && !(mem_ack_MC_i && last))`. Upstream therefore advances on the same edge as the final byte, so no instruction is re-issued.
- `mem_ack_MC_i` is ignored in IDLE.
- Reset (`rst_n` low, any time, mid-access included):
  - FSM goes to IDLE and `cnt` to 0.
  - All outputs go to 0 immediately.
  - A partially written store is not rolled back.

## Timing
- Non-memory instruction: write pulse 1 cycle after acceptance.
- Load with zero-wait ack, n bytes: presented in cycle 0, bytes acked in cycles 1..n, write pulse after the edge ending cycle n; `stall_CTRL_o` high in cycles 0..n-1.
- Each additional wait cycle on any byte adds exactly one cycle.
- Throughput: one instruction per cycle for non-memory instructions; memory ops take n+1 cycles minimum.
- `we_REG_o` is high for exactly one cycle per writing instruction. It is 0 in every other cycle, including IDLE with `valid_EX_i=0`.
- `waddr_REG_o` and `wdata_REG_o` hold their last value when `we_REG_o=0`.
- `mem_req_MC_o`, `mem_wr_MC_o`, `mem_addr_MC_o`, `mem_wdata_MC_o`, `we_REG_o`, `waddr_REG_o`, `wdata_REG_o` are registered (glitch-free); `stall_CTRL_o` is combinational.

## Structure
- Shared header (alongside `Enable`/`ZeroWord`): `funct3` load/store encodings, FSM state encodings, byte-count constants.
- One sub-module, `load_ext`: combinational; takes the 32-bit buffer and `funct3` and returns the sign/zero-extended word.
- Everything else lives in `mem_access_stage`.

## Test plan
- ALU op, `rd_EX_i=5`, `result_EX_i=0xDEADBEEF`, `rd_we_EX_i=1`:
  - Next cycle: `we_REG_o=1`, `waddr_REG_o=5`, `wdata_REG_o=0xDEADBEEF`.
  - `stall_CTRL_o` stays 0; `rd_EX_i=0` variant gives `we_REG_o=0`.
- LW at 0x100, memory holds 11 22 33 44, ack every cycle:
  - Addresses 0x100..0x103 issued.
  - `stall_CTRL_o` high for 4 cycles.
  - Write `0x44332211` after the 5th edge.
- Load extension:
  - LB of byte 0x80 gives `0xFFFFFF80`; LBU of 0x80 gives `0x00000080`.
  - LH of bytes 01 80 gives `0xFFFF8001`; LHU of the same gives `0x00008001`.
- SH at 0x300, `sdata_EX_i=0x1234ABCD`:
  - Writes 0xCD to 0x300, then 0xAB to 0x301.
  - `we_REG_o` stays 0.
- LW with 3 wait cycles before every ack:
  - Request, address and `stall_CTRL_o` held stable throughout.
  - Completes in 17 cycles; data correct.
- `rst_n` low after 2 bytes of an LW:
  - Same cycle: `mem_req_MC_o`, `stall_CTRL_o`, `we_REG_o` all 0.
  - After release: a new LB completes normally from IDLE.
